// File: rtl/spike_buf_pkg.sv
// Neuron-wide spike packet constants and field layout shared by the router
// ejection path, the spike buffer and the axon decoder.
package spike_buf_pkg;

  localparam int FLIT_SIZE          = 4;
  localparam int PACKET_SIZE        = 32;
  localparam int FLITS_PER_PACKET   = PACKET_SIZE / FLIT_SIZE;

  localparam int X_ADDRESS_LENGTH   = 8;
  localparam int Y_ADDRESS_LENGTH   = 8;
  localparam int AXON_CNT_BIT_WIDTH = 8;

  localparam int X_ADDRESS_OFFSET   = 0;
  localparam int Y_ADDRESS_OFFSET   = X_ADDRESS_OFFSET + X_ADDRESS_LENGTH;
  localparam int AXON_ID_OFFSET     = 16;

  typedef struct packed {
    logic [PACKET_SIZE-AXON_ID_OFFSET-AXON_CNT_BIT_WIDTH-1:0] rsvd;
    logic [AXON_CNT_BIT_WIDTH-1:0]                            axon_id;
    logic [Y_ADDRESS_LENGTH-1:0]                              y_addr;
    logic [X_ADDRESS_LENGTH-1:0]                              x_addr;
  } spike_pkt_t;

endpackage

// File: rtl/spike_buf_mem.sv
// Flit storage for spike_buf: one flit-wide write port and a combinational
// read port returning a whole packet (lane 0 in the low bits).
module spike_buf_mem
  import spike_buf_pkg::*;
#(
  parameter int FLIT_W = FLIT_SIZE,
  parameter int FPP    = FLITS_PER_PACKET,
  parameter int DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(DEPTH*FPP)-1:0]  wr_addr,
  input  logic [FLIT_W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0]      rd_pkt,
  output logic [FLIT_W*FPP-1:0]         rd_data
);

  localparam int ADDR_W = $clog2(DEPTH*FPP);
  localparam int LANE_W = $clog2(FPP);

  logic [FLIT_W-1:0] mem_r [DEPTH][FPP];

  // Flit write; upper address bits select the packet row, lower bits the lane.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr[ADDR_W-1:LANE_W]][wr_addr[LANE_W-1:0]] <= wr_data;
    end
  end

  for (genvar i = 0; i < FPP; i++) begin : g_lane
    assign rd_data[i*FLIT_W +: FLIT_W] = mem_r[rd_pkt][i];
  end

endmodule

// File: rtl/spike_buf.sv
// Flit-to-packet width-converting FIFO between the router ejection port and
// the spike register; a packet is visible only once all its flits are stored.
module spike_buf #(
  parameter int FLIT_SIZE   = spike_buf_pkg::FLIT_SIZE,
  parameter int PACKET_SIZE = spike_buf_pkg::PACKET_SIZE,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wrreq,
  input  logic [FLIT_SIZE-1:0]   data,
  input  logic                   rdreq,
  output logic [PACKET_SIZE-1:0] q,
  output logic                   rdempty,
  output logic                   wrfull
);
  import spike_buf_pkg::*;

  localparam int FPP    = PACKET_SIZE / FLIT_SIZE;
  localparam int SLOTS  = DEPTH * FPP;
  localparam int ADDR_W = $clog2(SLOTS);
  localparam int PKT_W  = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0]      wr_ptr_r;
  logic [PKT_W-1:0]       rd_pkt_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_nxt_s;
  logic                   rdempty_r;
  logic                   wrfull_r;
  logic [PACKET_SIZE-1:0] q_r;
  logic [PACKET_SIZE-1:0] rd_data_s;
  logic                   wr_acc_s;
  logic                   rd_acc_s;

  spike_buf_mem #(
    .FLIT_W (FLIT_SIZE),
    .FPP    (FPP),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data),
    .rd_pkt  (rd_pkt_r),
    .rd_data (rd_data_s)
  );

  // Accept decisions use the registered flags, so a read never frees room for a same-cycle write.
  always_comb begin
    wr_acc_s    = wrreq && !wrfull_r;
    rd_acc_s    = rdreq && !rdempty_r;
    count_nxt_s = count_r;
    if (wr_acc_s && rd_acc_s) begin
      count_nxt_s = count_r - CNT_W'(FPP - 1);
    end else if (wr_acc_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (rd_acc_s) begin
      count_nxt_s = count_r - CNT_W'(FPP);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, flit count, registered flags and the output packet register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_pkt_r  <= '0;
      count_r   <= '0;
      q_r       <= '0;
      rdempty_r <= 1'b1;
      wrfull_r  <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (rd_acc_s) begin
        rd_pkt_r <= rd_pkt_r + PKT_W'(1);
        q_r      <= rd_data_s;
      end
      count_r   <= count_nxt_s;
      rdempty_r <= (count_nxt_s < CNT_W'(FPP));
      wrfull_r  <= (count_nxt_s == CNT_W'(SLOTS));
    end
  end

  assign q       = q_r;
  assign rdempty = rdempty_r;
  assign wrfull  = wrfull_r;

endmodule

// File: tb/tb_spike_buf.sv
// Directed vector bench for spike_buf: table of single-cycle vectors plus
// hand-written fill, streaming and mid-packet reset sequences.
module tb_spike_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrreq;
  logic [3:0]  data;
  logic        rdreq;
  logic [31:0] q;
  logic        rdempty;
  logic        wrfull;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [3:0]  d;
    logic        rd;
    logic        exp_empty;
    logic        exp_full;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  spike_buf #(
    .FLIT_SIZE   (4),
    .PACKET_SIZE (32),
    .DEPTH       (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrreq   (wrreq),
    .data    (data),
    .rdreq   (rdreq),
    .q       (q),
    .rdempty (rdempty),
    .wrfull  (wrfull)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [3:0] d, input logic r);
    wrreq = w;
    data  = d;
    rdreq = r;
    @(posedge clk);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  task automatic add_vec(input logic w, input logic [3:0] d, input logic r,
                         input logic e, input logic f, input logic [31:0] eq);
    vec_t v;
    v.wr = w; v.d = d; v.rd = r; v.exp_empty = e; v.exp_full = f; v.exp_q = eq;
    vq.push_back(v);
  endtask

  function automatic logic [3:0] fill_pat(input int i);
    return 4'(i * 5 + i / 8);
  endfunction

  function automatic logic [31:0] fill_pkt(input int p);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < 8; k++) v[k*4 +: 4] = fill_pat(p * 8 + k);
    return v;
  endfunction

  function automatic logic [3:0] stream_pat(input int i);
    return 4'(i * 7 + 3 + i / 16);
  endfunction

  function automatic logic [31:0] stream_pkt(input int p);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < 8; k++) v[k*4 +: 4] = stream_pat(p * 8 + k);
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sent;
    int          rcvd;
    int          mcnt;
    logic        w;
    logic        r;
    logic        wacc;
    logic        racc;
    logic [31:0] newpkt;

    rst_n = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = 4'h0;

    // single-cycle vectors: 8-flit packet, then 7-flit partial completed later
    for (int i = 0; i < 7; i++) add_vec(1'b1, 4'(i + 1), 1'b0, 1'b1, 1'b0, 32'h0);
    add_vec(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h87654321);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h87654321);
    for (int i = 0; i < 7; i++) add_vec(1'b1, 4'(i + 9), 1'b0, 1'b1, 1'b0, 32'h87654321);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h87654321);
    add_vec(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h87654321);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h87654321);
    add_vec(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h87654321);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0FEDCBA9);

    // reset state, both while held and after release
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold rdempty", 32'(rdempty), 32'h1);
    check("rst_hold wrfull", 32'(wrfull), 32'h0);
    check("rst_hold q", q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel rdempty", 32'(rdempty), 32'h1);
    check("rst_rel wrfull", 32'(wrfull), 32'h0);
    check("rst_rel q", q, 32'h0);
    step(1'b0, 4'h0, 1'b1);
    check("rd_when_empty q", q, 32'h0);
    check("rd_when_empty rdempty", 32'(rdempty), 32'h1);

    foreach (vq[i]) begin
      step(vq[i].wr, vq[i].d, vq[i].rd);
      check($sformatf("vec%0d rdempty", i), 32'(rdempty), 32'(vq[i].exp_empty));
      check($sformatf("vec%0d wrfull", i), 32'(wrfull), 32'(vq[i].exp_full));
      check($sformatf("vec%0d q", i), q, vq[i].exp_q);
    end

    // fill all 128 slots
    for (int i = 0; i < 128; i++) begin
      step(1'b1, fill_pat(i), 1'b0);
      check($sformatf("fill%0d wrfull", i), 32'(wrfull), 32'(i == 127));
      check($sformatf("fill%0d rdempty", i), 32'(rdempty), 32'(i < 7));
    end
    step(1'b1, 4'hA, 1'b0);
    check("over_full wrfull", 32'(wrfull), 32'h1);
    // read and write together while full: only the read is accepted
    step(1'b1, 4'hB, 1'b1);
    check("full_rdwr q", q, fill_pkt(0));
    check("full_rdwr wrfull", 32'(wrfull), 32'h0);
    for (int p = 1; p < 16; p++) begin
      step(1'b0, 4'h0, 1'b1);
      check($sformatf("drain%0d q", p), q, fill_pkt(p));
      check($sformatf("drain%0d rdempty", p), 32'(rdempty), 32'(p == 15));
    end

    // continuous streaming with rdreq = ~rdempty, crossing the pointer wrap
    sent = 0;
    rcvd = 0;
    mcnt = 0;
    for (int cyc = 0; cyc < 2000 && rcvd < 40; cyc++) begin
      w = (sent < 40 * 8);
      r = !rdempty;
      step(w, stream_pat(sent), r);
      wacc = w && (mcnt != 128);
      racc = r && (mcnt >= 8);
      if (wacc) sent++;
      mcnt = mcnt + (wacc ? 1 : 0) - (racc ? 8 : 0);
      if (racc) begin
        check($sformatf("stream pkt%0d q", rcvd), q, stream_pkt(rcvd));
        rcvd++;
      end
      check($sformatf("stream cyc%0d rdempty", cyc), 32'(rdempty), 32'(mcnt < 8));
      check($sformatf("stream cyc%0d wrfull", cyc), 32'(wrfull), 32'(mcnt == 128));
    end
    check("stream received", 32'(rcvd), 32'd40);

    // asynchronous reset with 3 packets plus 5 flits stored
    for (int i = 0; i < 29; i++) step(1'b1, fill_pat(i), 1'b0);
    check("pre_rst rdempty", 32'(rdempty), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst rdempty", 32'(rdempty), 32'h1);
    check("mid_rst wrfull", 32'(wrfull), 32'h0);
    check("mid_rst q", q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    newpkt = 32'hC0FFEE12;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, newpkt[k*4 +: 4], 1'b0);
      check($sformatf("post_rst wr%0d rdempty", k), 32'(rdempty), 32'(k < 7));
    end
    step(1'b0, 4'h0, 1'b1);
    check("post_rst q", q, 32'hC0FFEE12);
    check("post_rst rdempty", 32'(rdempty), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_buf.md
# spike_buf

Single-clock, width-converting FIFO that buffers spike packets arriving from the router one 4-bit flit at a time and delivers them as complete 32-bit packets to the neuron's interface logic. It sits between the router's ejection port and the spike register that decodes axon IDs. A packet becomes readable only when all 8 of its flits have been written.

## Interface
- FLIT_SIZE, 4: write-port width in bits.
- PACKET_SIZE, 32: read-port width; must be an integer multiple of FLIT_SIZE.
- DEPTH, 16: capacity in complete packets; power of two, ≥2.
- clk  input  1  single clock for both ports, rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- wrreq  input  1  write one flit this cycle.
- data  input  FLIT_SIZE  flit to write.
- rdreq  input  1  pop one packet this cycle.
- q  output  PACKET_SIZE  last popped packet, registered.
- rdempty  output  1  fewer than PACKETS_FLITS (= PACKET_SIZE/FLIT_SIZE, 8) flits stored.
- wrfull  output  1  storage holds DEPTH×8 flits; no room for another flit.

## Operation
- Storage is DEPTH×8 flit slots; write pointer, read pointer and occupancy counted in flits (count width log2(DEPTH×8)+1).
- Write: if wrreq && !wrfull, data stored at the write pointer; pointer advances by 1, wrapping modulo DEPTH×8. wrreq while wrfull is dropped; no state changes.
- Packet assembly is little-endian: the first flit written after a packet boundary occupies q[3:0], the 8th occupies q[31:28].
- Read: if rdreq && !rdempty, the 8 flits at the read pointer are loaded into q; read pointer advances by 8 (wraps). rdreq while rdempty is ignored; q holds.
- q holds its value until the next accepted read.
- Simultaneous accepted write and read: count changes by +1−8 = −7 in one cycle. Accept decisions use wrfull/rdempty as registered at the start of the cycle; a read does not free space for a same-cycle write while wrfull=1.
- Partial packets (1–7 trailing flits) stay invisible; rdempty stays 1 until the 8th flit lands.
- Flit count 0..DEPTH×8; count never overflows or underflows given the gating above.

## Timing
- Reset (asynchronous on rst_n falling, held while low): pointers and count = 0, q = 0, rdempty = 1, wrfull = 0. Stored data need not be cleared. Reset mid-packet discards all flits, including partial ones.
- rdempty and wrfull are registered, derived from the updated count at each rising edge.
- Write-to-visible latency: the 8th flit written at edge N → rdempty = 0 after edge N.
- Read latency: rdreq sampled high at edge N with rdempty = 0 → q updated at edge N, readable in the cycle after N. A consumer that registers rdreq uses the delayed flag as "q valid".
- A consumer that drives rdreq = ~rdempty pops one packet per cycle while packets are available.
- wrfull asserts after the edge that writes the (DEPTH×8)th flit. It deasserts after the first accepted read.

## Structure
- Shared package, neuron-wide: FLIT_SIZE, PACKET_SIZE, FLITS_PER_PACKET, and the packet field offsets used downstream.
  - x_address_length = 8, y_address_length = 8.
  - Axon ID at bits [16 +: AXON_CNT_BIT_WIDTH].
- Put the flit storage array in one sub-module, spike_buf_mem. It is a simple dual-port RAM, FLIT_SIZE wide, DEPTH×8 deep, with one write port and an 8-flit-wide read port.
- Pointer, count and flag logic live in spike_buf.

## Test plan
- Reset: after rst_n is released → rdempty = 1, wrfull = 0, q = 0; rdreq is ignored and q stays 0.
- Write flits 0x1..0x8 on consecutive cycles:
  - rdempty stays 1 through the 7th flit and drops after the 8th.
  - rdreq for one cycle → q = 0x87654321 and rdempty = 1.
- Write 7 flits only → rdempty stays 1 indefinitely and rdreq has no effect.
  - Write 1 more flit → packet readable.
- Fill 128 flits (16 packets):
  - wrfull = 1 after the last flit.
  - A 129th wrreq is dropped.
  - One read → wrfull = 0.
  - Then read all packets back in order with correct data.
- Continuous streaming:
  - Writer sends 8 flits per packet nonstop.
  - rdreq = ~rdempty.
  - Every packet is received exactly once, in order.
  - A simultaneous write and read keeps count consistent, including across pointer wrap.
- Assert rst_n low with 3 packets plus 5 flits stored → immediate rdempty = 1, wrfull = 0, q = 0.
  - After release, a new packet reads back uncorrupted.
